// File: rtl/vid_mux_ctrl.sv
// vid_mux_ctrl: drives the video multiplexer select in manual, failover or timed-scan mode.
// Define VID_MUX_CTRL_STATS_EN to build the switch/frame statistics counters.
module vid_mux_ctrl #(
  parameter int NIN              = 5,
  parameter int LGTIMEOUT        = 20,
  parameter int DEF_SELECT       = 0,
  parameter int OPT_TUSER_IS_SOF = 0
) (
  input  logic                     S_AXI_ACLK,
  input  logic                     S_AXI_ARESETN,
  input  logic [NIN-1:0]           S_VID_VALID,
  input  logic                     M_VID_VALID,
  input  logic                     M_VID_READY,
  input  logic                     M_VID_LAST,
  input  logic                     M_VID_USER,
  input  logic [1:0]               i_mode,
  input  logic [$clog2(NIN)-1:0]   i_manual_sel,
  input  logic [NIN-1:0]           i_enable_mask,
  input  logic [7:0]               i_scan_frames,
  output logic [$clog2(NIN)-1:0]   o_select,
  output logic [NIN-1:0]           o_alive,
  output logic                     o_none_alive,
  output logic                     o_switch,
  output logic [15:0]              o_switch_count,
  output logic [15:0]              o_frame_count
);

  localparam int SW        = $clog2(NIN);
  localparam int DEF_CLAMP = (DEF_SELECT >= 0 && DEF_SELECT < NIN) ? DEF_SELECT : 0;
  localparam logic [SW-1:0] SEL_RST       = SW'(DEF_CLAMP);
  localparam logic [1:0]    MODE_FAILOVER = 2'd1;
  localparam logic [1:0]    MODE_SCAN     = 2'd2;

  logic [SW-1:0]  sel_reg, sel_next;
  logic           switch_reg;
  logic [7:0]     scan_cnt_reg, scan_cnt_next;
  logic [1:0]     mode_reg;

  logic [NIN-1:0] alive;
  logic [NIN-1:0] eligible;
  logic [NIN-1:0] elig_rot;
  logic           frame_end;
  logic           man_ok;
  logic           man_elig;
  logic           cur_elig;
  logic           any_elig;
  logic           scan_found;
  logic           scan_done;
  logic           mode_change;
  logic [8:0]     scan_target;
  logic [SW-1:0]  low_idx;
  logic [SW-1:0]  scan_idx;

  // Saturated counter means the source has been silent long enough to be dead.
  genvar gi;
  for (gi = 0; gi < NIN; gi++) begin : g_wd
    logic [LGTIMEOUT-1:0] wd_reg;
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN)
        wd_reg <= '1;
      else if (S_VID_VALID[gi])
        wd_reg <= '0;
      else if (wd_reg != '1)
        wd_reg <= wd_reg + LGTIMEOUT'(1);
    end
    assign alive[gi] = (wd_reg != '1);
  end

  assign eligible    = alive & i_enable_mask;
  assign frame_end   = M_VID_VALID & M_VID_READY &
                       ((OPT_TUSER_IS_SOF != 0) ? M_VID_USER : M_VID_LAST);
  assign man_ok      = (int'(i_manual_sel) < NIN);
  assign mode_change = (i_mode != mode_reg);
  assign scan_target = (i_scan_frames == 8'd0) ? 9'd1 : {1'b0, i_scan_frames};
  assign scan_done   = (({1'b0, scan_cnt_reg} + 9'd1) >= scan_target);
  assign any_elig    = |eligible;

  // Bit j of elig_rot is source (sel+1+j) mod NIN; the doubled vector makes the wrap free.
  assign elig_rot = NIN'({eligible, eligible} >> ({1'b0, sel_reg} + 1'b1));

  function automatic logic [SW-1:0] wrap_idx(input logic [SW-1:0] base, input int step);
    int t;
    t = int'(base) + 1 + step;
    if (t >= NIN)
      t = t - NIN;
    return SW'(t);
  endfunction

  always_comb begin
    man_elig   = 1'b0;
    cur_elig   = 1'b0;
    low_idx    = '0;
    scan_idx   = sel_reg;
    scan_found = 1'b0;
    for (int i = 0; i < NIN; i++) begin
      if (eligible[i] && i_manual_sel == SW'(i))
        man_elig = 1'b1;
      if (eligible[i] && sel_reg == SW'(i))
        cur_elig = 1'b1;
    end
    // Descending loops leave the lowest hit, so the nearest candidate wins.
    for (int i = NIN - 1; i >= 0; i--) begin
      if (eligible[i])
        low_idx = SW'(i);
      if (elig_rot[i]) begin
        scan_found = 1'b1;
        scan_idx   = wrap_idx(sel_reg, i);
      end
    end
  end

  always_comb begin
    sel_next      = sel_reg;
    scan_cnt_next = 8'd0;
    case (i_mode)
      MODE_FAILOVER: begin
        if (man_elig)
          sel_next = i_manual_sel;
        else if (cur_elig)
          sel_next = sel_reg;
        else if (any_elig)
          sel_next = low_idx;
      end
      MODE_SCAN: begin
        if (!mode_change) begin
          if (frame_end && scan_done) begin
            if (scan_found)
              sel_next = scan_idx;
          end else if (frame_end) begin
            scan_cnt_next = scan_cnt_reg + 8'd1;
          end else begin
            scan_cnt_next = scan_cnt_reg;
          end
        end
      end
      default: begin
        if (man_ok)
          sel_next = i_manual_sel;
      end
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      sel_reg      <= SEL_RST;
      switch_reg   <= 1'b0;
      scan_cnt_reg <= 8'd0;
      mode_reg     <= 2'd0;
    end else begin
      sel_reg      <= sel_next;
      switch_reg   <= (sel_next != sel_reg);
      scan_cnt_reg <= scan_cnt_next;
      mode_reg     <= i_mode;
    end
  end

  assign o_select     = sel_reg;
  assign o_switch     = switch_reg;
  assign o_alive      = alive;
  assign o_none_alive = ~any_elig;

`ifdef VID_MUX_CTRL_STATS_EN
  logic [15:0] switch_count_reg;
  logic [15:0] frame_count_reg;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      switch_count_reg <= 16'd0;
      frame_count_reg  <= 16'd0;
    end else begin
      if (switch_reg && switch_count_reg != 16'hffff)
        switch_count_reg <= switch_count_reg + 16'd1;
      if (frame_end)
        frame_count_reg <= frame_count_reg + 16'd1;
    end
  end

  assign o_switch_count = switch_count_reg;
  assign o_frame_count  = frame_count_reg;
`else
  assign o_switch_count = 16'd0;
  assign o_frame_count  = 16'd0;
`endif

endmodule

// File: tb/tb_vid_mux_ctrl.sv
// Bench for vid_mux_ctrl: directed stimulus, per-cycle model comparison, literal spot checks.
`timescale 1ns/1ps
module tb_vid_mux_ctrl;

  localparam int NIN  = 5;
  localparam int LGT  = 4;
  localparam int DEAD = (1 << LGT) - 1;

  logic           clk;
  logic           rst_n;
  logic [NIN-1:0] s_valid;
  logic           mv, mr, ml, mu;
  logic [1:0]     mode;
  logic [2:0]     man_sel;
  logic [NIN-1:0] mask;
  logic [7:0]     sf;
  logic [2:0]     o_select;
  logic [NIN-1:0] o_alive;
  logic           o_none_alive;
  logic           o_switch;
  logic [15:0]    o_switch_count;
  logic [15:0]    o_frame_count;

  vid_mux_ctrl #(
    .NIN(NIN), .LGTIMEOUT(LGT), .DEF_SELECT(7), .OPT_TUSER_IS_SOF(0)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .S_VID_VALID(s_valid),
    .M_VID_VALID(mv), .M_VID_READY(mr), .M_VID_LAST(ml), .M_VID_USER(mu),
    .i_mode(mode), .i_manual_sel(man_sel), .i_enable_mask(mask), .i_scan_frames(sf),
    .o_select(o_select), .o_alive(o_alive), .o_none_alive(o_none_alive),
    .o_switch(o_switch), .o_switch_count(o_switch_count), .o_frame_count(o_frame_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: liveness from the edge index of the last sampled VALID; select from the mode rules.
  int  seen_at[NIN];
  int  ecnt, m_sel, m_frames, m_prev_mode, m_swc, m_fc;
  bit  m_sw;
  bit  started;

  function automatic logic [NIN-1:0] model_alive();
    logic [NIN-1:0] a;
    for (int k = 0; k < NIN; k++)
      a[k] = (ecnt - seen_at[k] - 1) < DEAD;
    return a;
  endfunction

  function automatic bit model_fe();
    return mv && mr && ml;
  endfunction

  function automatic int model_target();
    return (sf == 8'd0) ? 1 : int'(sf);
  endfunction

  function automatic int model_next_sel();
    logic [NIN-1:0] el;
    int idx;
    el = model_alive() & mask;
    if (mode == 2'd2) begin
      if (int'(mode) != m_prev_mode || !model_fe() || m_frames + 1 < model_target())
        return m_sel;
      for (int k = 1; k <= NIN; k++) begin
        idx = (m_sel + k) % NIN;
        if (el[idx]) return idx;
      end
      return m_sel;
    end
    if (mode == 2'd1) begin
      if (int'(man_sel) < NIN) begin
        if (el[man_sel]) return int'(man_sel);
      end
      if (el[m_sel]) return m_sel;
      for (int k = 0; k < NIN; k++)
        if (el[k]) return k;
      return m_sel;
    end
    if (int'(man_sel) < NIN) return int'(man_sel);
    return m_sel;
  endfunction

  function automatic int model_next_frames();
    if (mode != 2'd2 || int'(mode) != m_prev_mode || model_next_sel() != m_sel)
      return 0;
    if (!model_fe()) return m_frames;
    if (m_frames + 1 >= model_target()) return 0;
    return m_frames + 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ecnt        <= 0;
      for (int k = 0; k < NIN; k++) seen_at[k] <= -1000;
      m_sel       <= 0;
      m_frames    <= 0;
      m_prev_mode <= 0;
      m_sw        <= 1'b0;
      m_swc       <= 0;
      m_fc        <= 0;
    end else begin
      m_sel       <= model_next_sel();
      m_sw        <= (model_next_sel() != m_sel);
      m_frames    <= model_next_frames();
      m_prev_mode <= int'(mode);
      for (int k = 0; k < NIN; k++)
        if (s_valid[k]) seen_at[k] <= ecnt;
      ecnt <= ecnt + 1;
      if (m_sw && m_swc < 65535) m_swc <= m_swc + 1;
      if (model_fe()) m_fc <= (m_fc + 1) % 65536;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("select", int'(o_select), m_sel);
      check("alive", int'(o_alive), int'(model_alive()));
      check("none_alive", int'(o_none_alive), int'((model_alive() & mask) == '0));
      check("switch", int'(o_switch), int'(m_sw));
`ifdef VID_MUX_CTRL_STATS_EN
      check("switch_count", int'(o_switch_count), m_swc);
      check("frame_count", int'(o_frame_count), m_fc);
`else
      check("switch_count", int'(o_switch_count), 0);
      check("frame_count", int'(o_frame_count), 0);
`endif
    end
  end

  // Stimulus helpers: enabled sources toggle VALID every cycle.
  logic [NIN-1:0] src_on;
  logic [NIN-1:0] applied;
  logic           phase;
  int             scan_seq[4] = '{2, 3, 4, 0};

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      s_valid = src_on & {NIN{phase}};
      applied = s_valid;
      phase   = ~phase;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame();
    mv = 1'b1; mr = 1'b1; ml = 1'b1;
    tick(1);
    mv = 1'b0; mr = 1'b0; ml = 1'b0;
    tick(1);
  endtask

  task automatic non_frames();
    mv = 1'b1; mr = 1'b0; ml = 1'b1;
    tick(1);
    mr = 1'b1; ml = 1'b0; mu = 1'b1;
    tick(1);
    mv = 1'b0; mr = 1'b0; mu = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int nsw;
    int exp_sel;
    rst_n = 1'b1; s_valid = '0; mv = 0; mr = 0; ml = 0; mu = 0;
    mode = 2'd0; man_sel = 3'd0; mask = '1; sf = 8'd2;
    src_on = '0; applied = '0; phase = 1'b0; started = 1'b0;
    #2 rst_n = 1'b0;
    started = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check("rst_select", int'(o_select), 0);
    check("rst_alive", int'(o_alive), 0);
    check("rst_none_alive", int'(o_none_alive), 1);
    check("rst_switch", int'(o_switch), 0);
    rst_n = 1'b1;
    tick(2);
    check("post_rst_switch", int'(o_switch), 0);
    check("post_rst_select", int'(o_select), 0);

    // Manual mode
    man_sel = 3'd3;
    tick(1);
    check("man_select", int'(o_select), 3);
    check("man_switch", int'(o_switch), 1);
    tick(1);
    check("man_switch_end", int'(o_switch), 0);
    man_sel = 3'd6;
    tick(3);
    check("man_oor_hold", int'(o_select), 3);

    // Failover
    src_on = 5'b10101; mode = 2'd1; man_sel = 3'd0; mask = '1;
    tick(4);
    check("fo_select0", int'(o_select), 0);
    check("fo_alive", int'(o_alive), 5'b10101);
    if (!applied[0]) tick(1);
    src_on = 5'b10100;
    n = 0;
    while (o_alive[0] && n < 40) begin
      tick(1);
      n++;
    end
    check("fo_dead_cycles", n, 15);
    check("fo_select_lag", int'(o_select), 0);
    tick(1);
    check("fo_select2", int'(o_select), 2);
    check("fo_switch", int'(o_switch), 1);
    src_on = 5'b10101;
    n = 0;
    do begin
      tick(1);
      n++;
    end while (!applied[0] && n < 4);
    check("fo_restore_alive", int'(o_alive[0]), 1);
    check("fo_restore_lag", int'(o_select), 2);
    tick(1);
    check("fo_revert", int'(o_select), 0);

    // Scan, two frames per source, source 1 masked off
    src_on = '1;
    tick(4);
    mode = 2'd2; mask = 5'b11101; sf = 8'd2;
    tick(2);
    exp_sel = 0;
    for (int i = 0; i < 4; i++) begin
      frame();
      non_frames();
      check("scan_hold", int'(o_select), exp_sel);
      frame();
      exp_sel = scan_seq[i];
      check("scan_step", int'(o_select), exp_sel);
    end
    sf = 8'd0;
    frame();
    check("scan_sf0_a", int'(o_select), 2);
    frame();
    check("scan_sf0_b", int'(o_select), 3);

    // Mode change coinciding with frame_end clears the count
    sf = 8'd2; man_sel = 3'd6;
    frame();
    mode = 2'd3; mv = 1; mr = 1; ml = 1;
    tick(1);
    mode = 2'd2;
    tick(1);
    mv = 0; mr = 0; ml = 0;
    tick(1);
    check("modechg_hold", int'(o_select), 3);
    frame();
    check("modechg_cnt1", int'(o_select), 3);
    frame();
    check("modechg_step", int'(o_select), 4);

    // All sources idle in failover
    mode = 2'd1; man_sel = 3'd0; mask = '1;
    tick(3);
    check("idle_pre_select", int'(o_select), 0);
    if (!applied[0]) tick(1);
    src_on = '0;
    nsw = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      nsw += int'(o_switch);
    end
    check("idle_switches", nsw, 0);
    check("idle_none_alive", int'(o_none_alive), 1);
    check("idle_select", int'(o_select), 0);

    // Statistics: 3 switches, 10 frames from a fresh reset
    rst_n = 1'b0;
    mode = 2'd0; man_sel = 3'd0;
    tick(2);
    check("rst2_switch_count", int'(o_switch_count), 0);
    check("rst2_frame_count", int'(o_frame_count), 0);
    rst_n = 1'b1;
    tick(1);
    for (int i = 1; i <= 3; i++) begin
      man_sel = 3'(i);
      tick(1);
    end
    for (int i = 0; i < 10; i++) frame();
    tick(2);
`ifdef VID_MUX_CTRL_STATS_EN
    check("stats_switches", int'(o_switch_count), 3);
    check("stats_frames", int'(o_frame_count), 10);
`else
    check("stats_switches", int'(o_switch_count), 0);
    check("stats_frames", int'(o_frame_count), 0);
`endif

    @(negedge clk);
    started = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/vid_mux_ctrl.md
# vid_mux_ctrl

Source-selection scheduler for the video input multiplexer. It watches every input stream for activity and counts frames on the multiplexed output. From that it drives the multiplexer's select input in one of three modes: manual, automatic failover, or timed scan. The multiplexer only acts on a new select at a frame boundary, so this block may change its select at any cycle.

## Interface

Parameters:
- NIN, 5: number of video sources.
- LGTIMEOUT, 20: width of the per-source inactivity watchdog; a source is dead after 2^LGTIMEOUT-1 cycles with no VALID.
- DEF_SELECT, 0: reset select; values ≥ NIN clamp to 0.
- OPT_TUSER_IS_SOF, 0: output frame marker. 1: end of frame is an accepted output beat with USER high (SOF). 0: end of frame is an accepted output beat with LAST high.

Ports:
- S_AXI_ACLK  in  1  clock.
- S_AXI_ARESETN  in  1  reset; one clock, asynchronous assert, active-low.
- S_VID_VALID  in  NIN  per-source TVALID, monitor only.
- M_VID_VALID  in  1  multiplexer output TVALID, monitor only.
- M_VID_READY  in  1  multiplexer output TREADY, monitor only.
- M_VID_LAST  in  1  multiplexer output TLAST, monitor only.
- M_VID_USER  in  1  multiplexer output TUSER, monitor only.
- i_mode  in  2  0 manual, 1 failover, 2 scan, 3 treated as manual.
- i_manual_sel  in  $clog2(NIN)  preferred/manual source.
- i_enable_mask  in  NIN  sources permitted in failover/scan.
- i_scan_frames  in  8  frames per source in scan; 0 treated as 1.
- o_select  out  $clog2(NIN)  select to multiplexer.
- o_alive  out  NIN  per-source liveness.
- o_none_alive  out  1  no source both alive and enabled.
- o_switch  out  1  one-cycle pulse when o_select changes.
- o_switch_count  out  16  select-change count (STATS).
- o_frame_count  out  16  output frame count (STATS).

## Operation

- Watchdog, one per source: an LGTIMEOUT-bit counter.
  - Clears to 0 on any cycle with S_VID_VALID[k] high.
  - Otherwise increments, saturating at all-ones.
  - o_alive[k] = counter ≠ all-ones.
  - A stalled source holds VALID high and therefore stays alive.
- eligible = o_alive & i_enable_mask. o_none_alive = ~|eligible.
- frame_end = M_VID_VALID & M_VID_READY & (OPT_TUSER_IS_SOF ? M_VID_USER : M_VID_LAST).
- Next-select rules:
  - Manual: i_manual_sel if < NIN, else hold.
  - Failover, in priority order:
    1. i_manual_sel, if eligible (revertive).
    2. Else current select, if eligible.
    3. Else the lowest-index eligible source.
    4. Else hold.
  - Scan:
    - An 8-bit frame counter increments on frame_end.
    - When the counter plus 1 ≥ max(i_scan_frames,1), select the next eligible index above current, wrapping modulo NIN. Current itself is the last candidate. Clear the counter.
    - If none is eligible, hold and clear the counter.
- The scan frame counter also clears on any o_select change and on any i_mode change.
- Out-of-range i_manual_sel is never forwarded in any mode.

## Timing

- Reset values:
  - o_select = clamped DEF_SELECT.
  - All watchdogs saturated, so o_alive = 0 and o_none_alive = 1.
  - o_switch = 0; counters = 0.
- o_select is registered and updates one cycle after the inputs that decide it.
- o_switch is high in the same cycle o_select shows its new value.
- Watchdog: S_VID_VALID high in cycle t gives o_alive high at t+1. Sustained VALID low from t gives o_alive low at t+2^LGTIMEOUT-1.
- Scan: the frame_end that completes the count moves o_select on the next edge.
- Simultaneous frame_end and mode change: the mode change wins and the counter clears.
- Reset asserted mid-operation returns all state to reset values immediately. No handshake output exists, so nothing can be violated.

## Configuration

- VID_MUX_CTRL_STATS_EN defined:
  - o_switch_count increments, saturating at 16'hffff, on each o_switch.
  - o_frame_count increments, wrapping, on each frame_end.
  - Both reset to 0.
- VID_MUX_CTRL_STATS_EN undefined: both outputs are constant 0 and the counters are not built. Ports exist in both builds.

## Test plan

- Bench setup: NIN=5, LGTIMEOUT=4 (dead after 15 idle cycles) in all scenarios.
- Reset with DEF_SELECT=7 -> o_select=0, o_alive=0, o_none_alive=1, no o_switch pulse.
- Manual mode, i_manual_sel 0→3 -> o_select=3 one cycle later, one o_switch pulse. i_manual_sel=6 -> o_select stays 3.
- Failover, sources 0,2,4 toggling VALID, mask 5'b11111, i_manual_sel=0; drop source 0 VALID -> 15 cycles later o_alive[0]=0, o_select=2. Restore source 0 -> o_select returns to 0 two cycles after its first VALID.
- Scan, i_scan_frames=2, all alive, source 1 masked off -> o_select sequence 0,2,3,4,0, changing after every second frame_end. i_scan_frames=0 -> changes every frame_end.
- All sources idle in failover -> o_none_alive=1, o_select held, no o_switch.
- STATS build: 3 switches and 10 frames -> o_switch_count=3, o_frame_count=10. Non-STATS build: both 0.
